// File: rtl/needle_heystack_matcher_pkg.sv
// Shared constants and types for the needle/heystack matcher slice.
// Default sizes, the byte width and the "no match" marker live here so every stage agrees on them.
package needle_heystack_matcher_pkg;

  localparam int STRING_SIZE_DEFAULT = 5;
  localparam int INDEX_BITS_DEFAULT  = 16;
  localparam int BYTE_W              = 8;

  localparam logic [INDEX_BITS_DEFAULT-1:0] NO_MATCH = '1;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/needle_heystack_matcher_match_window.sv
// Sliding STRING_SIZE-byte window over the heystack with a saturating fill counter.
// Flags a combinational hit when the candidate window (older bytes plus the incoming byte) equals the needle.
module needle_heystack_matcher_match_window
  import needle_heystack_matcher_pkg::*;
#(
  parameter int STRING_SIZE = STRING_SIZE_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            beat,
  input  logic                            last,
  input  byte_t                           data,
  input  logic [STRING_SIZE*BYTE_W-1:0]   needle,
  output logic                            hit,
  output logic                            window_full
);

  localparam int WIN_W  = STRING_SIZE * BYTE_W;
  localparam int FILL_W = $clog2(STRING_SIZE + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(STRING_SIZE);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(STRING_SIZE - 1);

  logic [WIN_W-1:0]  window_q;
  logic [WIN_W-1:0]  candidate;
  logic [FILL_W-1:0] fill_q;

  // The newest byte sits in the top byte lane, aligned with needle byte STRING_SIZE-1.
  generate
    if (STRING_SIZE == 1) begin : g_single
      assign candidate = data;
    end else begin : g_multi
      assign candidate = {data, window_q[WIN_W-1:BYTE_W]};
    end
  endgenerate

  // Counting the incoming byte, the window is full once STRING_SIZE-1 bytes are already held.
  assign window_full = (fill_q >= FILL_PRE);
  assign hit         = beat && window_full && (candidate == needle);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the window data is reset as well, so no X ever reaches the comparator after reset.
      window_q <= '0;
      fill_q   <= '0;
    end else if (beat) begin
      window_q <= candidate;
      if (last) begin
        fill_q <= '0;
      end else if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/needle_heystack_matcher.sv
// Counts (overlapping) needle occurrences per heystack and records the first match offset.
// One result record per heystack is presented through a valid/ready holding register.
module needle_heystack_matcher
  import needle_heystack_matcher_pkg::*;
#(
  parameter int STRING_SIZE = STRING_SIZE_DEFAULT,
  parameter int INDEX_BITS  = INDEX_BITS_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [STRING_SIZE*BYTE_W-1:0] needle,
  input  byte_t                         heystack_data,
  input  logic                          heystack_valid,
  input  logic                          heystack_last,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [INDEX_BITS-1:0]         result_count,
  output logic                          result_found,
  output logic [INDEX_BITS-1:0]         result_first,
  output logic                          result_dropped
);

  localparam logic [INDEX_BITS-1:0] ALL_ONES  = '1;
  localparam logic [INDEX_BITS-1:0] START_OFS = INDEX_BITS'(STRING_SIZE - 1);

  logic beat;
  logic last_beat;
  logic hit;
  logic window_full;

  logic [INDEX_BITS-1:0] byte_index_q, byte_index_d;
  logic [INDEX_BITS-1:0] count_q, count_d;
  logic [INDEX_BITS-1:0] first_q, first_d;
  logic                  found_q, found_d;
  logic [INDEX_BITS-1:0] match_start;

  assign beat      = heystack_valid & enable;
  assign last_beat = beat & heystack_last;

  needle_heystack_matcher_match_window #(
    .STRING_SIZE (STRING_SIZE)
  ) u_window (
    .clock       (clock),
    .reset       (reset),
    .beat        (beat),
    .last        (heystack_last),
    .data        (heystack_data),
    .needle      (needle),
    .hit         (hit),
    .window_full (window_full)
  );

  // Only meaningful once the window holds a full needle's worth of bytes.
  assign match_start = window_full ? (byte_index_q - START_OFS) : ALL_ONES;

  // Per-heystack statistics including the current beat; these also feed the result register.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    byte_index_d = byte_index_q;
    count_d      = count_q;
    first_d      = first_q;
    found_d      = found_q;
    if (beat) begin
      if (byte_index_q != ALL_ONES) begin
        byte_index_d = byte_index_q + 1'b1;
      end
      if (hit) begin
        if (count_q != ALL_ONES) begin
          count_d = count_q + 1'b1;
        end
        if (!found_q) begin
          first_d = match_start;
        end
        found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_index_q <= '0;
      count_q      <= '0;
      first_q      <= ALL_ONES;
      found_q      <= 1'b0;
    end else if (last_beat) begin
      byte_index_q <= '0;
      count_q      <= '0;
      first_q      <= ALL_ONES;
      found_q      <= 1'b0;
    end else begin
      byte_index_q <= byte_index_d;
      count_q      <= count_d;
      first_q      <= first_d;
      found_q      <= found_d;
    end
  end

  // Result holding register: a new record always wins; overwriting an unaccepted one is sticky-flagged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid   <= 1'b0;
      result_count   <= '0;
      result_found   <= 1'b0;
      result_first   <= ALL_ONES;
      result_dropped <= 1'b0;
    end else if (last_beat) begin
      result_valid <= 1'b1;
      result_count <= count_d;
      result_found <= found_d;
      result_first <= first_d;
      if (result_valid && !result_ready) begin
        result_dropped <= 1'b1;
      end
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_needle_heystack_matcher.sv
// Self-checking bench for needle_heystack_matcher: directed scenarios plus randomized heystacks
// compared against a naive substring-search reference model.
module tb_needle_heystack_matcher;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [39:0] needle;
  logic [7:0]  heystack_data;
  logic        heystack_valid;
  logic        heystack_last;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result_count;
  logic        result_found;
  logic [15:0] result_first;
  logic        result_dropped;

  int n_asserts = 0;
  int n_fail    = 0;
  logic exp_dropped = 1'b0;

  // Record layout: {valid, found, count, first, dropped}
  logic [34:0] got;
  logic [34:0] exp_rec;
  assign got = {result_valid, result_found, result_count, result_first, result_dropped};

  needle_heystack_matcher #(
    .STRING_SIZE (5),
    .INDEX_BITS  (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .needle         (needle),
    .heystack_data  (heystack_data),
    .heystack_valid (heystack_valid),
    .heystack_last  (heystack_last),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_count   (result_count),
    .result_found   (result_found),
    .result_first   (result_first),
    .result_dropped (result_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: brute-force scan of every start offset, overlaps included.
  function automatic void model(input logic [39:0] nd, input logic [7:0] hs[$],
                                output int cnt, output logic [15:0] first);
    logic ok;
    cnt   = 0;
    first = 16'hFFFF;
    for (int s = 0; s + 5 <= hs.size(); s++) begin
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (hs[s+k] != nd[8*k +: 8]) ok = 1'b0;
      end
      if (ok) begin
        if (cnt == 0) first = 16'(s);
        cnt++;
      end
    end
  endfunction

  function automatic logic [39:0] pack(input string s);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic void str_q(input string s, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  task automatic drive(input logic [7:0] b, input bit last, input bit en);
    @(negedge clock);
    heystack_data  = b;
    heystack_valid = 1'b1;
    heystack_last  = last;
    enable         = en;
  endtask

  task automatic go_idle();
    @(negedge clock);
    heystack_valid = 1'b0;
    heystack_last  = 1'b0;
    heystack_data  = 8'h00;
    enable         = 1'b1;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    for (int i = 0; i < q.size(); i++) drive(q[i], i == q.size() - 1, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    exp_rec = {1'b0, 1'b0, 16'd0, 16'hFFFF, 1'b0};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h (valid,found,count,first,dropped)", got, exp_rec);
    end
    n_asserts++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_match();
    logic [7:0] q[$];
    result_ready = 1'b1;
    needle = pack("hello");
    str_q("xhelloy", q);
    send_q(q);
    go_idle();
    exp_rec = {1'b1, 1'b1, 16'd1, 16'd1, exp_dropped};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL single_match: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_match_pulse: result_valid got %b expected 0", result_valid);
    end
    n_asserts++;
  endtask

  task automatic test_overlap();
    logic [7:0] q[$];
    needle = pack("aaaaa");
    str_q("aaaaaaa", q);
    send_q(q);
    go_idle();
    exp_rec = {1'b1, 1'b1, 16'd3, 16'd0, exp_dropped};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL overlap: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
  endtask

  task automatic test_short_then_full();
    logic [7:0] q[$];
    needle = pack("hello");
    str_q("hell", q);
    send_q(q);
    drive("h", 1'b0, 1'b1);
    exp_rec = {1'b1, 1'b0, 16'd0, 16'hFFFF, exp_dropped};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL short_heystack: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    drive("e", 1'b0, 1'b1);
    drive("l", 1'b0, 1'b1);
    drive("l", 1'b0, 1'b1);
    drive("o", 1'b1, 1'b1);
    go_idle();
    exp_rec = {1'b1, 1'b1, 16'd1, 16'd0, exp_dropped};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL no_carry_over: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    result_ready = 1'b0;
    needle = pack("hello");
    str_q("hello", q);
    send_q(q);
    drive("x", 1'b1, 1'b1);
    result_ready = 1'b1;
    go_idle();
    exp_rec = {1'b1, 1'b0, 16'd0, 16'hFFFF, 1'b0};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL accept_and_load: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_and_load_drop: result_valid got %b expected 0", result_valid);
    end
    n_asserts++;
  endtask

  task automatic test_drop();
    logic [7:0] q[$];
    result_ready = 1'b0;
    needle = pack("hello");
    str_q("hello", q);
    send_q(q);
    drive("z", 1'b0, 1'b1);
    exp_rec = {1'b1, 1'b1, 16'd1, 16'd0, 1'b0};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL drop_first_record: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    drive("z", 1'b1, 1'b1);
    go_idle();
    exp_dropped = 1'b1;
    exp_rec = {1'b1, 1'b0, 16'd0, 16'hFFFF, 1'b1};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL drop_overwrite: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL drop_hold: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    result_ready = 1'b1;
    @(negedge clock);
    exp_rec = {1'b0, 1'b0, 16'd0, 16'hFFFF, 1'b1};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL drop_release: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
  endtask

  task automatic test_enable_gap();
    needle = pack("hello");
    drive("h", 1'b0, 1'b1);
    drive("e", 1'b0, 1'b1);
    drive("l", 1'b0, 1'b1);
    drive("l", 1'b0, 1'b1);
    drive("q", 1'b0, 1'b0);
    drive("o", 1'b1, 1'b1);
    go_idle();
    exp_rec = {1'b1, 1'b1, 16'd1, 16'd0, exp_dropped};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL enable_gap: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    result_ready = 1'b0;
    needle = pack("hello");
    str_q("hello", q);
    send_q(q);
    go_idle();
    drive("h", 1'b0, 1'b1);
    drive("e", 1'b0, 1'b1);
    drive("l", 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    exp_dropped = 1'b0;
    exp_rec = {1'b0, 1'b0, 16'd0, 16'hFFFF, 1'b0};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
    heystack_valid = 1'b0;
    heystack_last  = 1'b0;
    reset          = 1'b0;
    result_ready   = 1'b1;
    send_q(q);
    go_idle();
    exp_rec = {1'b1, 1'b1, 16'd1, 16'd0, 1'b0};
    if (got !== exp_rec) begin
      n_fail++;
      $display("FAIL after_reset_mid: got %h expected %h", got, exp_rec);
    end
    n_asserts++;
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    logic [39:0] nd;
    logic [15:0] exp_first;
    int          exp_cnt;
    int          len;
    result_ready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 5; k++) nd[8*k +: 8] = 8'h61 + 8'($urandom_range(0, 1));
      needle = nd;
      len = $urandom_range(1, 18);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'h61 + 8'($urandom_range(0, 1)));
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 5))
          0: drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
          1: begin
            @(negedge clock);
            heystack_valid = 1'b0;
            heystack_last  = 1'b0;
          end
          default: ;
        endcase
        drive(q[i], i == len - 1, 1'b1);
      end
      go_idle();
      model(nd, q, exp_cnt, exp_first);
      exp_rec = {1'b1, exp_cnt != 0, 16'(exp_cnt), exp_first, exp_dropped};
      if (got !== exp_rec) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", it, got, exp_rec);
      end
      n_asserts++;
      @(negedge clock);
      if (result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL random_pulse_%0d: result_valid got %b expected 0", it, result_valid);
      end
      n_asserts++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    needle         = '0;
    heystack_data  = 8'h00;
    heystack_valid = 1'b0;
    heystack_last  = 1'b0;
    result_ready   = 1'b1;

    test_reset();
    test_single_match();
    test_overlap();
    test_short_then_full();
    test_back_to_back();
    test_drop();
    test_enable_gap();
    test_reset_mid();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
